// File: rtl/jno_branch_unit.sv
// jno_branch_unit: consumer of the JNO decoder's enable/enable_status/openpulse
// signals. Registers the decoder outputs, evaluates jump-if-no-overflow in a
// sampling window, updates the program counter and counts taken jumps.
module jno_branch_unit #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              enable_status,
    input  logic              openpulse,
    input  logic              sta,
    input  logic [ADDR_W-1:0] target,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  jump_count,
    output logic              busy,
    output logic              done,
    output logic              taken,
    output logic              conflict
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARM    = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    logic [1:0]        state;
    logic [WIN_W-1:0]  win_cnt;
    logic [ADDR_W-1:0] target_l;
    logic              enable_q;
    logic              enable_q_prev;
    logic              enable_status_q;
    logic              openpulse_q;
    logic              sta_q;
    logic              enable_rise;
    logic              take_now;
    logic              conflict_now;

    // One register stage on every decoder-side input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            enable_q        <= 1'b0;
            enable_q_prev   <= 1'b0;
            enable_status_q <= 1'b0;
            openpulse_q     <= 1'b0;
            sta_q           <= 1'b0;
        end else begin
            enable_q        <= enable;
            enable_q_prev   <= enable_q;
            enable_status_q <= enable_status;
            openpulse_q     <= openpulse;
            sta_q           <= sta;
        end
    end

    // Edge detect and the jump decision for an openpulse sampled this cycle.
    // The decision is resolved while still in ARM so that the registered
    // done/taken/conflict/pc all become visible together during COMMIT.
    always_comb begin
        enable_rise  = enable_q & ~enable_q_prev;
        take_now     = openpulse_q & enable_status_q & ~sta_q;
        conflict_now = openpulse_q & (sta_q | ~enable_status_q);
    end

    assign busy = (state != IDLE);

    // Evaluation FSM, program counter and taken-jump counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            win_cnt    <= '0;
            target_l   <= '0;
            pc         <= '0;
            jump_count <= '0;
            done       <= 1'b0;
            taken      <= 1'b0;
            conflict   <= 1'b0;
        end else begin
            done     <= 1'b0;
            taken    <= 1'b0;
            conflict <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_rise) begin
                        state    <= ARM;
                        win_cnt  <= '0;
                        target_l <= target;
                    end else if (advance) begin
                        pc <= pc + ADDR_W'(1);
                    end
                end
                ARM: begin
                    if (openpulse_q || (win_cnt == WIN_LAST)) begin
                        state    <= COMMIT;
                        done     <= 1'b1;
                        taken    <= take_now;
                        conflict <= conflict_now;
                        if (take_now) begin
                            pc <= target_l;
                            if (jump_count != '1) begin
                                jump_count <= jump_count + CNT_W'(1);
                            end
                        end else begin
                            pc <= pc + ADDR_W'(1);
                        end
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end
                COMMIT: begin
                    state <= DRAIN;
                end
                default: begin
                    if (!enable_q) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jno_branch_unit.sv
// tb_jno_branch_unit: directed and randomized JNO evaluations checked against
// a behavioural model of pc and jump_count.
module tb_jno_branch_unit;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 8;
    localparam int WINDOW = 16;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              enable_status;
    logic              openpulse;
    logic              sta;
    logic [ADDR_W-1:0] target;
    logic              advance;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  jump_count;
    logic              busy;
    logic              done;
    logic              taken;
    logic              conflict;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] pc_m;
    int         cnt_m;

    jno_branch_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .enable_status(enable_status),
        .openpulse(openpulse), .sta(sta), .target(target), .advance(advance),
        .pc(pc), .jump_count(jump_count), .busy(busy), .done(done),
        .taken(taken), .conflict(conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        int dn;
        dn = 0;
        advance = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) dn++;
            pc_m = pc_m + 8'd1;
        end
        advance = 1'b0;
        chk("adv_pc", 32'(pc), 32'(pc_m));
        chk("adv_nodone", 32'(dn), 32'd0);
        chk("adv_busy", 32'(busy), 32'd0);
    endtask

    // One JNO evaluation. d = pin-cycle delay from enable rise to openpulse
    // (0 = no openpulse). Model: jump iff openpulse arrives, no-overflow path
    // armed and no overflow; any advance while the evaluation is open is lost.
    task automatic jno(input logic st, input logic sa, input logic [7:0] tgt,
                       input int d, input bit rnd_adv, input int hold);
        int lat, dn, wait_n;
        logic o_taken, o_conf;
        logic [7:0] o_pc;
        logic exp_take, exp_conf, seen;
        lat = 0; dn = 0; o_taken = 1'b0; o_conf = 1'b0; o_pc = '0;
        enable_status = st; sta = sa; target = tgt; enable = 1'b1;
        for (int i = 1; i <= WINDOW + 8 + hold; i++) begin
            tick();
            if (done) begin
                dn++;
                if (lat == 0) begin
                    lat = i; o_taken = taken; o_conf = conflict; o_pc = pc;
                end
            end
            openpulse = (d > 0) && (i >= d) && (i < d + 4);
            advance = rnd_adv ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i == 2) target = ~tgt;
        end
        advance = 1'b0; openpulse = 1'b0;
        chk("jno_busy_held", 32'(busy), 32'd1);
        enable = 1'b0;
        wait_n = 0;
        while (busy !== 1'b0 && wait_n < 6) begin
            tick();
            wait_n++;
        end
        chk("jno_busy_fall", 32'(busy), 32'd0);

        seen     = (d > 0);
        exp_take = seen & st & ~sa;
        exp_conf = seen & (sa | ~st);
        if (exp_take) begin
            pc_m = tgt;
            if (cnt_m < 255) cnt_m++;
        end else begin
            pc_m = pc_m + 8'd1;
        end
        chk("jno_done_count", 32'(dn), 32'd1);
        chk("jno_latency_min", 32'(lat >= 3), 32'd1);
        chk("jno_latency_max", 32'(lat <= WINDOW + 3), 32'd1);
        chk("jno_taken", 32'(o_taken), 32'(exp_take));
        chk("jno_conflict", 32'(o_conf), 32'(exp_conf));
        chk("jno_pc_at_done", 32'(o_pc), 32'(pc_m));
        chk("jno_pc", 32'(pc), 32'(pc_m));
        chk("jno_count", 32'(jump_count), 32'(cnt_m));
    endtask

    initial begin
        int lat;
        reset = 1'b0; enable = 1'b0; enable_status = 1'b0; openpulse = 1'b0;
        sta = 1'b0; target = '0; advance = 1'b0;
        pc_m = '0; cnt_m = 0;

        // Reset state.
        repeat (3) tick();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_count", 32'(jump_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_taken", 32'(taken), 32'd0);
        chk("rst_conflict", 32'(conflict), 32'd0);
        reset = 1'b1;
        tick();

        adv(3);
        adv(2);

        // Taken jump from pc=5.
        jno(1'b1, 1'b0, 8'h40, 2, 1'b0, 0);

        // Not taken on timeout, from pc=0x10.
        jno(1'b1, 1'b0, 8'h10, 1, 1'b0, 0);
        jno(1'b1, 1'b1, 8'h99, 0, 1'b0, 0);

        // Fastest evaluation: done exactly 3 cycles after the enable pin rise.
        enable_status = 1'b1; sta = 1'b0; target = 8'h2A; enable = 1'b1;
        tick();
        openpulse = 1'b1;
        lat = 0;
        for (int i = 2; i <= 6; i++) begin
            tick();
            if (done && lat == 0) lat = i;
        end
        openpulse = 1'b0; enable = 1'b0;
        repeat (4) tick();
        pc_m = 8'h2A; cnt_m++;
        chk("fast_latency", 32'(lat), 32'd3);
        chk("fast_pc", 32'(pc), 32'(pc_m));

        // pc wrap.
        jno(1'b1, 1'b0, 8'hFF, 3, 1'b0, 0);
        adv(1);

        // Conflict paths.
        jno(1'b1, 1'b1, 8'h77, 1, 1'b0, 0);
        jno(1'b0, 1'b0, 8'h55, 4, 1'b0, 0);

        // Enable held long: a single evaluation.
        jno(1'b1, 1'b0, 8'h33, 2, 1'b0, 40);

        // Advance during the evaluation is dropped.
        jno(1'b1, 1'b0, 8'hC3, 5, 1'b1, 0);
        jno(1'b0, 1'b1, 8'h12, 0, 1'b1, 0);

        // Reset mid-evaluation.
        enable_status = 1'b1; sta = 1'b0; target = 8'hEE; enable = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1; enable = 1'b0;
        pc_m = '0; cnt_m = 0;
        chk("midrst_pc", 32'(pc), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_count", 32'(jump_count), 32'd0);
        repeat (3) tick();
        chk("midrst_nodone", 32'(done), 32'd0);
        jno(1'b1, 1'b0, 8'h81, 2, 1'b0, 0);

        // Randomized evaluations interleaved with sequential steps.
        for (int n = 0; n < 40; n++) begin
            adv(int'($urandom_range(0, 3)));
            jno(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)),
                ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, WINDOW - 2)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Fill the jump counter up to saturation, then one more taken jump.
        while (cnt_m < 255) begin
            jno(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1, 1'b0, 0);
        end
        jno(1'b1, 1'b0, 8'h5A, 1, 1'b0, 0);
        chk("sat_count", 32'(jump_count), 32'hFF);
        chk("sat_pc", 32'(pc), 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
